// File: rtl/fft_helpers_twiddle_sequencer_if.sv
// Twiddle message bus toward the butterfly array: val/rdy plus re/im and stage/butterfly indices.
// The master drives the message and val; the slave drives rdy.
interface fft_helpers_twiddle_sequencer_if #(
  parameter int N = 8,
  parameter int W = 32
);
  localparam int SW = $clog2($clog2(N));
  localparam int BW = $clog2(N) - 1;

  logic          send_val;
  logic          send_rdy;
  logic [W-1:0]  send_re;
  logic [W-1:0]  send_im;
  logic [SW-1:0] send_stage;
  logic [BW-1:0] send_bfly;
  logic          send_last;

  modport master (
    output send_val, send_re, send_im, send_stage, send_bfly, send_last,
    input  send_rdy
  );

  modport slave (
    input  send_val, send_re, send_im, send_stage, send_bfly, send_last,
    output send_rdy
  );
endinterface

// File: rtl/fft_helpers_twiddle_sequencer.sv
// Streams radix-2 DIT twiddles stage by stage, 1-cycle start latency, one message per cycle; held while send_rdy low.
// FFT_TWIDDLE_INVERSE_EN adds an `inverse` input that selects conjugate twiddles for the whole sequence.
module fft_helpers_twiddle_sequencer #(
  parameter int N = 8,
  parameter int W = 32,
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sine_in [N],
  input  logic         start,
`ifdef FFT_TWIDDLE_INVERSE_EN
  input  logic         inverse,
`endif
  output logic         busy,
  output logic         done,
  fft_helpers_twiddle_sequencer_if.master send
);
  localparam int S  = $clog2(N);
  localparam int SW = $clog2(S);
  localparam int BW = S - 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  if (W <= D + 1 || N < 4 || (1 << S) != N) begin : g_bad_params
    $error("fft_helpers_twiddle_sequencer: illegal N/W/D");
  end

  logic [0:0]    state;
  logic          hs;
  logic          load;
  logic          inv_eff;
  logic [SW-1:0] t_s;
  logic [BW-1:0] t_j;
  logic [S-1:0]  jm;
  logic [S-1:0]  k;
  logic [S-1:0]  ri;
  logic [W-1:0]  t_re;
  logic [W-1:0]  t_im;
  logic          t_last;
  int            sh;

`ifdef FFT_TWIDDLE_INVERSE_EN
  logic inv_q;
`endif

  assign hs   = send.send_val && send.send_rdy;
  assign load = (state == IDLE) ? start : (hs && !send.send_last);

  // Target indices: (0,0) when starting, otherwise the successor of the message on the bus.
  always_comb begin
    t_s = '0;
    t_j = '0;
    if (state == RUN) begin
      if (send.send_bfly == BW'(N / 2 - 1)) begin
        t_j = '0;
        t_s = send.send_stage + 1'b1;
      end else begin
        t_j = send.send_bfly + 1'b1;
        t_s = send.send_stage;
      end
    end
  end

  // k = (j mod 2^s) * 2^(S-1-s); the cosine lives a quarter period ahead in the sine table.
  always_comb begin
    jm = {1'b0, t_j} & S'((1 << t_s) - 1);
    sh = S - 1 - int'(t_s);
    k  = jm << sh;
    ri = k + S'(N / 4);
`ifdef FFT_TWIDDLE_INVERSE_EN
    inv_eff = (state == IDLE) ? inverse : inv_q;
`else
    inv_eff = 1'b0;
`endif
    t_re   = sine_in[ri];
    t_im   = inv_eff ? sine_in[k] : -sine_in[k];
    t_last = (t_s == SW'(S - 1)) && (t_j == BW'(N / 2 - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      send.send_val <= 1'b0;
`ifdef FFT_TWIDDLE_INVERSE_EN
      inv_q         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state         <= RUN;
          busy          <= 1'b1;
          send.send_val <= 1'b1;
`ifdef FFT_TWIDDLE_INVERSE_EN
          inv_q         <= inverse;
`endif
        end
      end else if (hs && send.send_last) begin
        state         <= IDLE;
        busy          <= 1'b0;
        send.send_val <= 1'b0;
        done          <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      send.send_re    <= '0;
      send.send_im    <= '0;
      send.send_stage <= '0;
      send.send_bfly  <= '0;
      send.send_last  <= 1'b0;
    end else if (load) begin
      send.send_re    <= t_re;
      send.send_im    <= t_im;
      send.send_stage <= t_s;
      send.send_bfly  <= t_j;
      send.send_last  <= t_last;
    end
  end
endmodule

// File: tb/tb_fft_helpers_twiddle_sequencer.sv
// Scoreboard bench for the twiddle sequencer at N=8, W=32, D=16 with a hand-computed twiddle table.
module tb_fft_helpers_twiddle_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] sine [8];
`ifdef FFT_TWIDDLE_INVERSE_EN
  logic        inverse;
`endif

  fft_helpers_twiddle_sequencer_if #(.N(8), .W(32)) send_if ();

  fft_helpers_twiddle_sequencer #(.N(8), .W(32), .D(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .sine_in (sine),
    .start   (start),
`ifdef FFT_TWIDDLE_INVERSE_EN
    .inverse (inverse),
`endif
    .busy    (busy),
    .done    (done),
    .send    (send_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [1:0]  stage;
    logic [1:0]  bfly;
    logic        last;
  } msg_t;

  // Expected order s-major: s0 k=0,0,0,0; s1 k=0,2,0,2; s2 k=0,1,2,3.
  logic [31:0] re_tab [12] = '{
    32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000,
    32'h00010000, 32'h00000000, 32'h00010000, 32'h00000000,
    32'h00010000, 32'h0000B505, 32'h00000000, 32'hFFFF4AFB};
  logic [31:0] im_tab [12] = '{
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'hFFFF0000, 32'h00000000, 32'hFFFF0000,
    32'h00000000, 32'hFFFF4AFB, 32'hFFFF0000, 32'hFFFF4AFB};

  msg_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hs_count = 0;
  bit   done_pend = 0;
  bit   stall = 0;
  msg_t held;
  msg_t cur;
  msg_t exp_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic push_seq(input bit inv);
    msg_t m;
    for (int i = 0; i < 12; i++) begin
      m.re    = re_tab[i];
      m.im    = inv ? -im_tab[i] : im_tab[i];
      m.stage = 2'(i / 4);
      m.bfly  = 2'(i % 4);
      m.last  = (i == 11);
      sb.push_back(m);
    end
  endtask

  // Drives start across one edge; returns just after the accepting edge.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  always @(negedge clk) begin
    cur = '{send_if.send_re, send_if.send_im, send_if.send_stage, send_if.send_bfly, send_if.send_last};
    if (reset) begin
      done_pend = 0;
      stall     = 0;
    end else begin
      if (done || done_pend) check("done_pulse", 32'(done), 32'(done_pend));
      done_pend = 0;
      if (stall && send_if.send_val) begin
        check("stall_re", cur.re, held.re);
        check("stall_im", cur.im, held.im);
        check("stall_idx", 32'({cur.stage, cur.bfly, cur.last}), 32'({held.stage, held.bfly, held.last}));
      end
      if (send_if.send_val && send_if.send_rdy) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_msg: got stage %0d bfly %0d, expected none", cur.stage, cur.bfly);
        end else begin
          exp_m = sb.pop_front();
          check("msg_re", cur.re, exp_m.re);
          check("msg_im", cur.im, exp_m.im);
          check("msg_stage", 32'(cur.stage), 32'(exp_m.stage));
          check("msg_bfly", 32'(cur.bfly), 32'(exp_m.bfly));
          check("msg_last", 32'(cur.last), 32'(exp_m.last));
          if (exp_m.last) done_pend = 1;
        end
        hs_count++;
      end
      stall = send_if.send_val && !send_if.send_rdy;
      held  = cur;
    end
  end

  int  cyc;
  bit  got_done;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    send_if.send_rdy = 1'b0;
`ifdef FFT_TWIDDLE_INVERSE_EN
    inverse = 1'b0;
`endif
    sine = '{32'h00000000, 32'h0000B505, 32'h00010000, 32'h0000B505,
             32'h00000000, 32'hFFFF4AFB, 32'hFFFF0000, 32'hFFFF4AFB};

    repeat (3) @(posedge clk);
    #1;
    check("rst_val", 32'(send_if.send_val), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_re", send_if.send_re, 32'd0);
    check("rst_im", send_if.send_im, 32'd0);
    check("rst_idx", 32'({send_if.send_stage, send_if.send_bfly, send_if.send_last}), 32'd0);
    reset = 1'b0;

    // Full-rate sequence: 12 messages back to back, done one cycle after the last.
    push_seq(1'b0);
    send_if.send_rdy = 1'b1;
    pulse_start();
    check("lat_val", 32'(send_if.send_val), 32'd1);
    check("lat_busy", 32'(busy), 32'd1);
    cyc = 0;
    got_done = 0;
    while (cyc < 40 && !got_done) begin
      @(posedge clk); #1;
      cyc++;
      got_done = done;
    end
    check("done_cycle", 32'(cyc), 32'd12);
    check("busy_after", 32'(busy), 32'd0);
    check("val_after", 32'(send_if.send_val), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("sb_empty_1", 32'(sb.size()), 32'd0);

    // Random backpressure.
    push_seq(1'b0);
    pulse_start();
    got_done = 0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      send_if.send_rdy = 1'(($urandom % 3) != 0);
      @(posedge clk); #1;
      got_done = done;
    end
    send_if.send_rdy = 1'b1;
    check("bp_done_seen", 32'(got_done), 32'd1);
    check("sb_empty_2", 32'(sb.size()), 32'd0);

    // Extra starts mid-sequence are ignored; reset at message 5 aborts.
    repeat (2) @(posedge clk);
    push_seq(1'b0);
    hs_count = 0;
    pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("abort_val", 32'(send_if.send_val), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hs", 32'(hs_count), 32'd4);
    check("abort_remaining", 32'(sb.size()), 32'd8);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done), 32'd0);

    // Restart after abort begins again at s=0, j=0.
    push_seq(1'b0);
    pulse_start();
    got_done = 0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(posedge clk); #1;
      got_done = done;
    end
    check("restart_done", 32'(got_done), 32'd1);
    check("sb_empty_3", 32'(sb.size()), 32'd0);

`ifdef FFT_TWIDDLE_INVERSE_EN
    // Conjugate twiddles; start lands in the cycle after the previous done pulse.
    push_seq(1'b1);
    inverse = 1'b1;
    pulse_start();
    inverse = 1'b0;
    got_done = 0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(posedge clk); #1;
      got_done = done;
    end
    check("inv_done", 32'(got_done), 32'd1);
    check("sb_empty_inv", 32'(sb.size()), 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
